// File: rtl/star_pixel_scanner.sv
// Raster-order readback of the 160x120 framebuffer, handing the (x, y) of every
// TARGET_COLOUR pixel downstream over valid/ready. Optional hit counter: STAR_SCAN_COUNT_EN.
module star_pixel_scanner #(
    parameter logic [2:0] TARGET_COLOUR = 3'b111,
    parameter int         WIDTH         = 160,
    parameter int         HEIGHT        = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic [14:0] mem_address,
    input  logic [2:0]  mem_q,
    output logic [7:0]  star_x,
    output logic [6:0]  star_y,
    output logic        star_valid,
    input  logic        star_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  star_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    // y*160 + x as y*128 + y*32 + x, formed in 16 bits and truncated
    function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [15:0] sum;
        sum = {2'b00, y, 7'b000_0000} + {4'b0000, y, 5'b0_0000} + {8'h00, x};
        return sum[14:0];
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [14:0] mem_address_q, mem_address_d;
    logic [7:0]  star_x_q, star_x_d;
    logic [6:0]  star_y_q, star_y_d;
    logic        star_valid_q, star_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        advance_s;
    logic        last_pixel_s;

    // Next-state, counter advance and hit capture
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        star_x_d     = star_x_q;
        star_y_d     = star_y_q;
        advance_s    = 1'b0;
        last_pixel_s = (x_q == X_LAST) && (y_q == Y_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADDR;
                    x_d     = 8'd0;
                    y_d     = 7'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                if (mem_q == TARGET_COLOUR) begin
                    state_d  = EMIT;
                    star_x_d = x_q;
                    star_y_d = y_q;
                end else begin
                    advance_s = 1'b1;
                end
            end
            EMIT: begin
                if (star_ready) begin
                    advance_s = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The final pixel ends the scan without wrapping the counters
        if (advance_s) begin
            if (last_pixel_s) begin
                state_d = DONE;
            end else if (x_q == X_LAST) begin
                state_d = ADDR;
                x_d     = 8'd0;
                y_d     = y_q + 7'd1;
            end else begin
                state_d = ADDR;
                x_d     = x_q + 8'd1;
            end
        end else begin
            x_d = x_d;
        end

        mem_address_d = pixel_addr(x_d, y_d);
        star_valid_d  = (state_d == EMIT);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    // State, scan counters and registered outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            mem_address_q <= 15'd0;
            star_x_q      <= 8'd0;
            star_y_q      <= 7'd0;
            star_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mem_address_q <= mem_address_d;
            star_x_q      <= star_x_d;
            star_y_q      <= star_y_d;
            star_valid_q  <= star_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_address = mem_address_q;
    assign star_x      = star_x_q;
    assign star_y      = star_y_q;
    assign star_valid  = star_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef STAR_SCAN_COUNT_EN
    logic [7:0] count_q, count_d;

    // Saturating count of completed handshakes, cleared by an accepted start
    always_comb begin
        count_d = count_q;
        if ((state_q == IDLE) && start) begin
            count_d = 8'd0;
        end else if ((state_q == EMIT) && star_ready && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Hit counter register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign star_count = count_q;
`else
    assign star_count = 8'd0;
`endif

endmodule

// File: tb/tb_star_pixel_scanner.sv
// Randomized bench for star_pixel_scanner: a frame with 300 star pixels (corners and
// (37,52) forced), random consumer stalls, an aborted scan and restarts.
module tb_star_pixel_scanner;

    localparam int NPIX  = 19200;
    localparam int NHITS = 300;
`ifdef STAR_SCAN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [14:0] mem_address;
    logic [2:0]  mem_q;
    logic [7:0]  star_x;
    logic [6:0]  star_y;
    logic        star_valid;
    logic        star_ready;
    logic        busy;
    logic        done;
    logic [7:0]  star_count;

    always #10 clock = ~clock;

    star_pixel_scanner dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .mem_address(mem_address),
        .mem_q      (mem_q),
        .star_x     (star_x),
        .star_y     (star_y),
        .star_valid (star_valid),
        .star_ready (star_ready),
        .busy       (busy),
        .done       (done),
        .star_count (star_count)
    );

    // Framebuffer with a one-cycle synchronous read
    logic [2:0] fb [0:NPIX-1];
    always @(posedge clock) mem_q <= fb[mem_address];

    int vectors     = 0;
    int miscompares = 0;

    // Model: expected hits in raster order, plus elapsed-cycle bookkeeping
    int hitq[$];
    bit active;
    int c;
    int stalls;
    int hs;
    int scan_hits;
    bit prev_hold;
    int stall_left;
    bit rand_ready;
    int first_valid_c;
    int done_c;
    int cnt_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (scan cycle %0d)", name, act, exp, c);
        end
    endtask

    function automatic int exp_count();
        if (!CNT_EN) return 0;
        return (hs > 255) ? 255 : hs;
    endfunction

    task automatic build_queue();
        hitq.delete();
        for (int a = 0; a < NPIX; a++) begin
            if (fb[a] == 3'b111) hitq.push_back(a);
        end
        scan_hits = hitq.size();
    endtask

    // One clock: compare at the falling edge, then drive ready/start for the next rising edge
    task automatic step(input bit drive_start);
        int exp_done;
        @(negedge clock);
        if (active) begin
            c++;
            exp_done = 38400 + scan_hits + stalls;
            chk("done", done, c == exp_done);
            chk("busy", busy, c <= exp_done);
            chk("star_count", star_count, exp_count());
            if (c == 0) chk("scan_start_addr", mem_address, 0);
            if (prev_hold) chk("valid_held", star_valid, 1'b1);
            if (star_valid) begin
                if (hitq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_valid: got star_valid 1, expected 0 (scan cycle %0d)", c);
                end else begin
                    chk("star_x", star_x, hitq[0] % 160);
                    chk("star_y", star_y, hitq[0] / 160);
                    chk("emit_addr", mem_address, hitq[0]);
                    if (hitq[0] == 8357) chk("addr_37_52", mem_address, 15'd8357);
                    if (first_valid_c < 0) first_valid_c = c;
                end
            end
            if (done && done_c < 0) begin
                done_c   = c;
                cnt_done = star_count;
            end
            if (c == exp_done) begin
                chk("hits_left", hitq.size(), 0);
                chk("end_addr", mem_address, 19199);
            end
            if (c > exp_done) active = 1'b0;
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_valid", star_valid, 1'b0);
            chk("idle_count", star_count, exp_count());
        end

        if (active && star_valid && hitq.size() != 0) begin
            if (hitq[0] == 8357 && stall_left > 0) begin
                star_ready = 1'b0;
                stall_left--;
            end else begin
                star_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            if (star_ready) begin
                void'(hitq.pop_front());
                hs++;
                prev_hold = 1'b0;
            end else begin
                stalls++;
                prev_hold = 1'b1;
            end
        end else begin
            star_ready = 1'($urandom_range(1, 0));
            prev_hold  = 1'b0;
        end

        start = drive_start;
        if (drive_start && !active) begin
            active        = 1'b1;
            c             = -1;
            stalls        = 0;
            hs            = 0;
            first_valid_c = -1;
            done_c        = -1;
            build_queue();
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clock);
        resetn    = 1'b1;
        active    = 1'b0;
        hs        = 0;
        prev_hold = 1'b0;
        chk("rst_mem_address", mem_address, 15'd0);
        chk("rst_star_x", star_x, 8'd0);
        chk("rst_star_y", star_y, 7'd0);
        chk("rst_star_valid", star_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_star_count", star_count, 8'd0);
    endtask

    initial begin
        int n;
        int a;
        resetn     = 1'b0;
        start      = 1'b0;
        star_ready = 1'b0;
        active     = 1'b0;
        c          = 0;
        stalls     = 0;
        hs         = 0;
        scan_hits  = 0;
        prev_hold  = 1'b0;
        stall_left = 0;
        rand_ready = 1'b1;
        done_c     = -1;
        cnt_done   = -1;

        for (int i = 0; i < NPIX; i++) fb[i] = 3'($urandom_range(6, 0));
        fb[0]     = 3'b111;
        fb[159]   = 3'b111;
        fb[8357]  = 3'b111;
        fb[19199] = 3'b111;
        n = 4;
        while (n < NHITS) begin
            a = $urandom_range(NPIX - 1, 0);
            if (fb[a] != 3'b111) begin
                fb[a] = 3'b111;
                n++;
            end
        end

        repeat (2) @(negedge clock);
        do_reset();
        repeat (3) step(1'b0);

        // Full scan: random stalls, ten-cycle stall at (37,52), ignored mid-scan start
        stall_left = 10;
        step(1'b1);
        for (int i = 0; i < 45000 && active; i++) step(i == 777);
        if (active) begin
            vectors++;
            miscompares++;
            $display("FAIL scan_timeout: got busy scan after 45000 cycles, expected done");
            active = 1'b0;
        end
        chk("first_hit_cycle", first_valid_c, 2);
        chk("done_cycle", done_c, 38400 + NHITS + stalls);
        chk("count_at_done", cnt_done, CNT_EN ? 255 : 0);
        chk("last_star_x", star_x, 8'd159);
        chk("last_star_y", star_y, 7'd119);
        repeat (3) step(1'b0);

        // Restart (clears the count), then abort around pixel 5000
        step(1'b1);
        while (active && c < 10000) step(1'b0);
        do_reset();
        repeat (20) step(1'b0);

        // A fresh scan after the abort starts from address 0
        step(1'b1);
        repeat (100) step(1'b0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
